// File: rtl/tpu_pkg.sv
// Shared TPU types and default sizes used by the operand feeders and the MAC array.
package tpu_pkg;
   localparam int BITS_AB = 8;
   localparam int BITS_C  = 32;
   localparam int DIM     = 8;

   typedef logic signed [BITS_AB-1:0] operand_t;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } feeder_state_t;
endpackage

// File: rtl/tpu_a_feeder_if.sv
// Load/stream bus between the host load path, the A feeder and the array's west edge.
interface tpu_a_feeder_if #(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8
) ();
   logic                       en;
   logic                       WrEn;
   logic [$clog2(DIM)-1:0]     Arow;
   logic [DIM*BITS_AB-1:0]     Ain;
   logic                       start;
   logic [DIM*BITS_AB-1:0]     Aout;
   logic                       valid;
   logic                       busy;
   logic                       done;

   // Host / testbench side
   modport master (
      output en, WrEn, Arow, Ain, start,
      input  Aout, valid, busy, done
   );

   // Feeder side
   modport slave (
      input  en, WrEn, Arow, Ain, start,
      output Aout, valid, busy, done
   );
endinterface

// File: rtl/tpu_feed_lane.sv
// One west-edge lane: stores one tile row and emits element (col - LANE), or 0 outside the row.
module tpu_feed_lane #(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8,
   parameter int LANE    = 0,
   parameter int TW      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [DIM*BITS_AB-1:0]        row_in,
   input  logic                          load,
   input  logic                          clear,
   input  logic [TW-1:0]                 col,
   output logic signed [BITS_AB-1:0]     aout
);
   logic signed [BITS_AB-1:0] row_q [DIM];
   logic signed [BITS_AB-1:0] row_d [DIM];
   logic signed [BITS_AB-1:0] elem;
   logic signed [BITS_AB-1:0] aout_q, aout_d;

   // Row buffer update: whole row replaced on a decoded write
   always_comb begin
      for (int j = 0; j < DIM; j++) begin
         row_d[j] = row_q[j];
         if (wr_en) row_d[j] = row_in[j*BITS_AB +: BITS_AB];
      end
   end

   // Skew select: this lane sees element j at column LANE+j, padding is exactly zero
   always_comb begin
      elem = '0;
      for (int j = 0; j < DIM; j++) begin
         if (int'(col) == LANE + j) elem = row_q[j];
      end
   end

   // Lane output: cleared at end of stream, loaded on each advancing column, else held
   always_comb begin
      aout_d = aout_q;
      if (clear)     aout_d = '0;
      else if (load) aout_d = elem;
   end

   // Lane registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < DIM; j++) row_q[j] <= '0;
         aout_q <= '0;
      end else begin
         for (int j = 0; j < DIM; j++) row_q[j] <= row_d[j];
         aout_q <= aout_d;
      end
   end

   assign aout = aout_q;
endmodule

// File: rtl/tpu_a_feeder.sv
// A-operand feeder: buffers a DIM x DIM tile by rows and streams it diagonally skewed into the array.
module tpu_a_feeder #(
   parameter int BITS_AB = tpu_pkg::BITS_AB,
   parameter int DIM     = tpu_pkg::DIM
) (
   input  logic          clk,
   input  logic          rst,
   tpu_a_feeder_if.slave bus
);
   import tpu_pkg::*;

   localparam int TW   = $clog2(2*DIM-1);
   localparam int LAST = 2*DIM-2;

   feeder_state_t state_q, state_d;
   logic [TW-1:0] t_q, t_d;       // index of the column currently on Aout
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic accept, advance, finish, row_wr;

   assign accept  = (state_q == IDLE) && bus.start && bus.en;
   assign finish  = (state_q == STREAM) && bus.en && (t_q == TW'(LAST));
   assign advance = (state_q == STREAM) && bus.en && !finish;
   // Start wins over a same-cycle write; writes are never taken mid-stream
   assign row_wr  = (state_q == IDLE) && bus.WrEn && !bus.start;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state: leave IDLE on an accepted start, return after the last column
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = STREAM;
         STREAM:  if (finish) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/counter next values; a stalled stream (en=0) holds everything but done
   always_comb begin
      t_d     = t_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (accept) begin
         t_d     = '0;
         valid_d = 1'b1;
         busy_d  = 1'b1;
      end else if (advance) begin
         t_d     = t_q + TW'(1);
      end else if (finish) begin
         t_d     = '0;
         valid_d = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b1;
      end
   end

   // Counter and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t_q     <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         t_q     <= t_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

   // One lane per array row; lanes present the column the counter is moving to
   genvar gi;
   generate
      for (gi = 0; gi < DIM; gi++) begin : g_lane
         logic signed [BITS_AB-1:0] lane_out;

         tpu_feed_lane #(
            .BITS_AB (BITS_AB),
            .DIM     (DIM),
            .LANE    (gi),
            .TW      (TW)
         ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (row_wr && (bus.Arow == ($clog2(DIM))'(gi))),
            .row_in (bus.Ain),
            .load   (accept || advance),
            .clear  (finish),
            .col    (t_d),
            .aout   (lane_out)
         );

         assign bus.Aout[gi*BITS_AB +: BITS_AB] = lane_out;
      end
   endgenerate
endmodule

// File: tb/tb_tpu_a_feeder.sv
// Directed bench for tpu_a_feeder at DIM=4: load, skewed stream, stall, collisions, signed data, reset.
module tb_tpu_a_feeder;
   localparam int W = 8;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst;

   tpu_a_feeder_if #(.BITS_AB(W), .DIM(D)) bus ();

   tpu_a_feeder #(.BITS_AB(W), .DIM(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] a_m [D][D];   // expected tile contents

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   // advance one clock and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_col(input int t);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < D; i++) begin
         if (t - i >= 0 && t - i < D) r[i*W +: W] = a_m[i][t-i];
      end
      return r;
   endfunction

   function automatic logic [31:0] pack_row(input int i);
      logic [31:0] r;
      for (int j = 0; j < D; j++) r[j*W +: W] = a_m[i][j];
      return r;
   endfunction

   task automatic write_row(input int i, input logic [31:0] data);
      bus.WrEn = 1'b1;
      bus.Arow = 2'(i);
      bus.Ain  = data;
      step();
      bus.WrEn = 1'b0;
   endtask

   // Starting right after the accept edge: check all 2D-1 columns, then the done pulse
   task automatic full_stream(input string name);
      for (int t = 0; t < 2*D-1; t++) begin
         $display("%s t=%0d Aout=%h valid=%b busy=%b", name, t, bus.Aout, bus.valid, bus.busy);
         check($sformatf("%s_col%0d", name, t), 64'(bus.Aout), 64'(exp_col(t)));
         check($sformatf("%s_valid%0d", name, t), 64'(bus.valid), 64'd1);
         step();
      end
      check({name, "_done"}, 64'(bus.done), 64'd1);
      check({name, "_end_valid"}, 64'(bus.valid), 64'd0);
      check({name, "_end_busy"}, 64'(bus.busy), 64'd0);
      check({name, "_end_aout"}, 64'(bus.Aout), 64'd0);
      step();
      check({name, "_done_clear"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      int vcnt;
      logic [31:0] hand [7];

      bus.en = 1'b1; bus.WrEn = 1'b0; bus.Arow = '0; bus.Ain = '0; bus.start = 1'b0;
      rst = 1'b1;
      #2;
      check("rst_aout", 64'(bus.Aout), 64'd0);
      check("rst_valid", 64'(bus.valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      step();
      rst = 1'b0;
      step();

      // load A[i][j] = 0x10*(i+1)+(j+1)
      for (int i = 0; i < D; i++) begin
         for (int j = 0; j < D; j++) a_m[i][j] = 8'(16*(i+1) + (j+1));
         write_row(i, pack_row(i));
         $display("load row %0d = %h", i, pack_row(i));
      end

      // basic stream with hand-computed columns
      hand[0] = 32'h00000011; hand[1] = 32'h00002112; hand[3] = 32'h41322314; hand[6] = 32'h44000000;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      vcnt = 0;
      for (int t = 0; t < 2*D-1; t++) begin
         $display("basic t=%0d Aout=%h valid=%b", t, bus.Aout, bus.valid);
         if (t == 0 || t == 1 || t == 3 || t == 6)
            check($sformatf("basic_hand%0d", t), 64'(bus.Aout), 64'(hand[t]));
         else
            check($sformatf("basic_col%0d", t), 64'(bus.Aout), 64'(exp_col(t)));
         if (bus.valid) vcnt++;
         step();
      end
      check("basic_valid_cycles", 64'(vcnt), 64'd7);
      check("basic_done", 64'(bus.done), 64'd1);
      check("basic_end_valid", 64'(bus.valid), 64'd0);
      step();
      check("basic_done_clear", 64'(bus.done), 64'd0);

      // stall at t=2 with a mid-stream write to row 0 that must be ignored
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.WrEn = 1'b1; bus.Arow = 2'd0; bus.Ain = 32'hFFFFFFFF;
      step();
      bus.WrEn = 1'b0;
      step();
      check("stall_t2", 64'(bus.Aout), 64'h00312213);
      bus.en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         $display("stall k=%0d Aout=%h valid=%b", k, bus.Aout, bus.valid);
         check($sformatf("stall_hold%0d", k), 64'(bus.Aout), 64'h00312213);
         check($sformatf("stall_valid%0d", k), 64'(bus.valid), 64'd1);
         check($sformatf("stall_busy%0d", k), 64'(bus.busy), 64'd1);
      end
      bus.en = 1'b1;
      for (int t = 3; t < 2*D-1; t++) begin
         step();
         $display("resume t=%0d Aout=%h", t, bus.Aout);
         check($sformatf("resume_col%0d", t), 64'(bus.Aout), 64'(exp_col(t)));
      end
      step();
      check("stall_done", 64'(bus.done), 64'd1);
      step();

      // start and write in the same IDLE cycle: write dropped, old tile streamed
      bus.start = 1'b1; bus.WrEn = 1'b1; bus.Arow = 2'd0; bus.Ain = 32'hAAAAAAAA;
      step();
      bus.start = 1'b0; bus.WrEn = 1'b0;
      check("restream_t0", 64'(bus.Aout), 64'h00000011);
      full_stream("restream");

      // signed operand passes through untouched
      a_m[2][1] = 8'h80;
      write_row(2, 32'h34338031);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int t = 0; t < 3; t++) step();
      $display("signed t=3 Aout=%h", bus.Aout);
      check("signed_lane2", 64'(bus.Aout[23:16]), 64'h80);
      check("signed_col3", 64'(bus.Aout), 64'h41802314);
      for (int t = 3; t < 2*D-1; t++) step();
      check("signed_done", 64'(bus.done), 64'd1);
      step();

      // asynchronous reset at t=4
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int t = 0; t < 4; t++) step();
      check("prereset_busy", 64'(bus.busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      $display("reset mid-stream Aout=%h valid=%b busy=%b done=%b", bus.Aout, bus.valid, bus.busy, bus.done);
      check("arst_aout", 64'(bus.Aout), 64'd0);
      check("arst_valid", 64'(bus.valid), 64'd0);
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_done", 64'(bus.done), 64'd0);
      #1 rst = 1'b0;
      for (int i = 0; i < D; i++)
         for (int j = 0; j < D; j++) a_m[i][j] = 8'h00;
      step();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      full_stream("zeros");

      // start with en=0 ignored, accepted one cycle later with en=1
      a_m[0][0] = 8'h04; a_m[0][1] = 8'h03; a_m[0][2] = 8'h02; a_m[0][3] = 8'h01;
      write_row(0, 32'h01020304);
      bus.en = 1'b0; bus.start = 1'b1;
      step();
      check("ign_busy", 64'(bus.busy), 64'd0);
      check("ign_valid", 64'(bus.valid), 64'd0);
      bus.en = 1'b1;
      step();
      bus.start = 1'b0;
      check("late_t0", 64'(bus.Aout), 64'h00000004);
      full_stream("late");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/tpu_a_feeder.md
Name: tpu_a_feeder

Overview:
Transmit-side companion to the systolic MAC array. It buffers a DIM x DIM tile of A operands, one row per write, then streams it into the array's west edge with diagonal skew. Lane i receives A[i][t-i] at stream cycle t, so every MAC in the array sees operands arriving in step with its row and column position. It sits between the host/CSR load path and the Ain inputs of the array's first column, and shares the array's en stall.

Parameters:
BITS_AB, 8, signed operand width (matches the MAC cell's A/B width)
DIM, 8, array dimension; tile rows, lanes, and elements per row

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
en  input  1  array-wide advance enable; low = stall (same signal that drives the MAC cells)
WrEn  input  1  write one tile row into the buffer
Arow  input  $clog2(DIM)  row index for WrEn
Ain  input  DIM*BITS_AB  row data; element j at bits [j*BITS_AB +: BITS_AB]
start  input  1  begin streaming the buffered tile
Aout  output  DIM*BITS_AB  skewed lane outputs to the array; lane i at [i*BITS_AB +: BITS_AB], signed
valid  output  1  Aout carries a stream column this cycle
busy  output  1  high while in STREAM
done  output  1  one-cycle pulse after the final stream column

Behaviour:
- Reset (async, rst=1): buffer, Aout, valid, busy, and done all go to 0. The state goes to IDLE and the counter t goes to 0. Reset mid-stream aborts immediately, with no done pulse.
- States: IDLE and STREAM. Stream counter t runs 0..2*DIM-2 (2*DIM-1 columns).
- IDLE:
  - WrEn=1 with start=0 writes buffer[Arow] <= Ain at the clock edge, independent of en.
  - start=1 with en=1 moves to STREAM and sets t=0 at that edge. Start has priority, so WrEn in the same cycle is dropped.
  - start with en=0 is ignored; start is level-sampled, not latched.
- STREAM, at each edge with en=1, registered outputs are:
  - Aout lane i = buffer[i][t-i] when 0 <= t-i < DIM, else 0
  - valid=1, busy=1
  - then t increments.
- First column: appears on Aout in the cycle after start is accepted (1-cycle latency).
- STREAM with en=0: t, Aout, valid, and busy all hold.
- After the edge that emits t=2*DIM-2:
  - next en=1 edge returns to IDLE with Aout=0, valid=0, busy=0, and done=1 for exactly one cycle.
  - done clears on the following edge regardless of en.
- WrEn or start while busy: ignored. The buffer must not change mid-stream.
- The buffer is retained after streaming, so a second start re-streams the same tile.
- Data pass through unmodified: no sign extension or arithmetic; padding is exactly 0.

Decomposition:
- Shared package tpu_pkg holds:
  - BITS_AB, BITS_C, DIM defaults
  - typedef operand_t = logic signed [BITS_AB-1:0]
  - typedef feeder_state_t {IDLE, STREAM}
- One natural sub-module, tpu_feed_lane, instantiated DIM times with lane index i:
  - holds one row of DIM operands
  - outputs element t-i or 0 given the shared counter t and en
- The top level owns the FSM, counter t, valid/busy/done, and row-write decode.

Test Plan:
- Load and stream, DIM=4, A[i][j]=0x10*(i+1)+(j+1), then start with en=1:
  - t=0: Aout lanes {0x11,0,0,0}
  - t=1: {0x12,0x21,0,0}
  - t=3: {0x14,0x23,0x32,0x41}
  - t=6: {0,0,0,0x44}
  - valid high exactly 7 cycles; done pulses once on the next cycle.
- Stall: drop en for 3 cycles at t=2. Aout holds {0x13,0x22,0x31,0} and valid stays 1; the sequence resumes at t=3 with no column skipped or repeated.
- Collisions:
  - WrEn to row 0 with Ain=0xFF.. during STREAM is ignored; a re-stream still yields 0x11 at t=0.
  - start+WrEn in the same IDLE cycle streams the old row and drops the write.
- Signed data: A[2][1]=0x80 (-128) appears as 0x80 on lane 2 at t=3, with no sign change.
- Reset mid-stream: assert rst at t=4. Aout, valid, busy, done go to 0 asynchronously and the buffer clears. A subsequent start streams all zeros for 7 cycles and then pulses done.
- Ignored start: start with en=0 in IDLE gives busy=0 and valid=0; the same start with en=1 one cycle later begins streaming normally.
